// File: rtl/twm_row_accum.sv
// -----------------------------------------------------------------------------
// twm_row_accum
//
// Event-driven sparse MAC stage. Pops active-neuron addresses from the address
// FIFO, reads the matching row of the transposed weight memory (TWM) and adds
// every lane of that row into its own signed, saturating accumulator. Neurons
// that never reach the FIFO cost no cycles at all.
//
// Pipeline (one row per cycle):
//   cycle t   : en_fetch pops the FIFO
//   cycle t+1 : addr_fetch is valid -> mem_rd_en / mem_rd_addr   (v1_q)
//   cycle t+2 : mem_rd_data is valid -> accumulators updated     (v2_q)
//
// Ports
//   clk_f         fast clock
//   rst           synchronous reset, active-high (aborts any pass)
//   start         1-cycle pulse, clears accumulators and begins a pass (IDLE only)
//   gen_finished  level from the address generator: all addresses pushed
//   empty_fifo    address FIFO empty flag (registered in the FIFO)
//   en_fetch      pop request to the address FIFO
//   addr_fetch    popped address, valid the cycle after en_fetch
//   mem_rd_en     TWM read strobe
//   mem_rd_addr   TWM row address, holds its last value while mem_rd_en=0
//   mem_rd_data   TWM row, lane i = [i*BW_W +: BW_W], valid the cycle after mem_rd_en
//   acc_out       live accumulators, lane i = [i*BW_ACC +: BW_ACC]
//   acc_valid     1-cycle pulse when acc_out holds the final sums of a pass
//   busy          high while a pass is running or draining
// -----------------------------------------------------------------------------
module twm_row_accum #(
   parameter int NUM_OUT = 16,
   parameter int BW_W    = 8,
   parameter int BW_ACC  = 16,   // must be >= BW_W
   parameter int BW_ADDR = 5
) (
   input  logic                      clk_f,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      gen_finished,
   input  logic                      empty_fifo,
   output logic                      en_fetch,
   input  logic [BW_ADDR-1:0]        addr_fetch,
   output logic                      mem_rd_en,
   output logic [BW_ADDR-1:0]        mem_rd_addr,
   input  logic [NUM_OUT*BW_W-1:0]   mem_rd_data,
   output logic [NUM_OUT*BW_ACC-1:0] acc_out,
   output logic                      acc_valid,
   output logic                      busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]         state_q, state_d;
   logic               gf_q, gf_d;
   logic               v1_q;
   logic               v2_q;
   logic [BW_ADDR-1:0] addr_hold_q;
   logic               run_done;
   logic               drain_done;
   logic               clear_acc;

   // ------------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------------
   always_comb begin
      en_fetch   = (state_q == S_RUN) && !empty_fifo;
      // en_fetch is only ever high with empty_fifo low, so "FIFO empty" here
      // already implies "no pop this cycle".
      run_done   = (state_q == S_RUN) && (gf_q || gen_finished) && empty_fifo;
      drain_done = (state_q == S_DRAIN) && !v1_q && !v2_q;
      clear_acc  = (state_q == S_IDLE) && start;

      state_d = state_q;
      gf_d    = gf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               gf_d    = 1'b0;
            end
         end
         S_RUN: begin
            // Sticky: the generator may pulse its finished flag while
            // addresses are still queued.
            gf_d = gf_q | gen_finished;
            if (run_done) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_f) begin
      if (rst) begin
         state_q     <= S_IDLE;
         gf_q        <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         addr_hold_q <= '0;
      end else begin
         state_q <= state_d;
         gf_q    <= gf_d;
         v1_q    <= en_fetch;
         v2_q    <= v1_q;
         if (v1_q) begin
            addr_hold_q <= addr_fetch;
         end
      end
   end

   // The popped address goes straight to the TWM; the hold register only
   // keeps the bus steady between reads.
   assign mem_rd_en   = v1_q;
   assign mem_rd_addr = v1_q ? addr_fetch : addr_hold_q;

   // acc_valid coincides with the DRAIN -> IDLE edge, so busy falls with it.
   assign acc_valid = drain_done;
   assign busy      = (state_q == S_RUN) || ((state_q == S_DRAIN) && !drain_done);

   // ------------------------------------------------------------------------
   // Per-lane saturating accumulators
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_lane
         logic [BW_ACC-1:0] acc_q;
         logic [BW_ACC-1:0] acc_d;
         logic [BW_W-1:0]   w_lane;
         logic [BW_ACC:0]   sum_wide;

         always_comb begin
            w_lane = mem_rd_data[gi*BW_W +: BW_W];
            // One guard bit is enough: |weight| never exceeds the accumulator
            // range, so the wide sum cannot wrap.
            sum_wide = {acc_q[BW_ACC-1], acc_q}
                     + {{(BW_ACC + 1 - BW_W){w_lane[BW_W-1]}}, w_lane};
            if (sum_wide[BW_ACC] != sum_wide[BW_ACC-1]) begin
               // Guard bit holds the true sign: clamp to the matching rail.
               acc_d = sum_wide[BW_ACC] ? {1'b1, {(BW_ACC-1){1'b0}}}
                                        : {1'b0, {(BW_ACC-1){1'b1}}};
            end else begin
               acc_d = sum_wide[BW_ACC-1:0];
            end
         end

         always_ff @(posedge clk_f) begin
            if (rst || clear_acc) begin
               acc_q <= '0;
            end else if (v2_q) begin
               acc_q <= acc_d;
            end
         end

         assign acc_out[gi*BW_ACC +: BW_ACC] = acc_q;
      end
   endgenerate

endmodule

// File: tb/tb_twm_row_accum.sv
`timescale 1ns/1ps
module tb_twm_row_accum;

   localparam int NUM_OUT = 16;
   localparam int BW_W    = 8;
   localparam int BW_ADDR = 5;
   localparam int ACC_A   = 16;   // default accumulator width
   localparam int ACC_B   = 8;    // narrow accumulator, exercises saturation

   logic clk_f = 1'b0;
   always #5 clk_f = ~clk_f;

   logic                     rst;
   logic                     start;
   logic                     gen_finished;
   logic                     empty_fifo = 1'b1;
   logic [BW_ADDR-1:0]       addr_fetch = '0;
   logic [NUM_OUT*BW_W-1:0]  mem_rd_data = '0;

   logic                     en_fetch_a, mem_rd_en_a, acc_valid_a, busy_a;
   logic [BW_ADDR-1:0]       mem_rd_addr_a;
   logic [NUM_OUT*ACC_A-1:0] acc_out_a;
   logic                     en_fetch_b, mem_rd_en_b, acc_valid_b, busy_b;
   logic [BW_ADDR-1:0]       mem_rd_addr_b;
   logic [NUM_OUT*ACC_B-1:0] acc_out_b;

   twm_row_accum #(.NUM_OUT(NUM_OUT), .BW_W(BW_W), .BW_ACC(ACC_A), .BW_ADDR(BW_ADDR)) dut_a (
      .clk_f(clk_f), .rst(rst), .start(start), .gen_finished(gen_finished),
      .empty_fifo(empty_fifo), .en_fetch(en_fetch_a), .addr_fetch(addr_fetch),
      .mem_rd_en(mem_rd_en_a), .mem_rd_addr(mem_rd_addr_a), .mem_rd_data(mem_rd_data),
      .acc_out(acc_out_a), .acc_valid(acc_valid_a), .busy(busy_a));

   twm_row_accum #(.NUM_OUT(NUM_OUT), .BW_W(BW_W), .BW_ACC(ACC_B), .BW_ADDR(BW_ADDR)) dut_b (
      .clk_f(clk_f), .rst(rst), .start(start), .gen_finished(gen_finished),
      .empty_fifo(empty_fifo), .en_fetch(en_fetch_b), .addr_fetch(addr_fetch),
      .mem_rd_en(mem_rd_en_b), .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(mem_rd_data),
      .acc_out(acc_out_b), .acc_valid(acc_valid_b), .busy(busy_b));

   // ---------------- environment: address FIFO and TWM ----------------
   logic                    push_req;
   logic [BW_ADDR-1:0]      push_addr;
   logic [BW_ADDR-1:0]      fifo_q[$];
   logic [NUM_OUT*BW_W-1:0] twm[32];
   logic [BW_ADDR-1:0]      pass_addrs[$];   // addresses of the current pass, in order

   always @(posedge clk_f) begin
      if (rst) begin
         fifo_q.delete();
         empty_fifo <= 1'b1;
      end else begin
         if (en_fetch_a && fifo_q.size() > 0) addr_fetch <= fifo_q.pop_front();
         if (push_req) fifo_q.push_back(push_addr);
         empty_fifo <= (fifo_q.size() == 0);
      end
   end

   always @(posedge clk_f) begin
      if (mem_rd_en_a) mem_rd_data <= twm[mem_rd_addr_a];
   end

   int checks = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   function automatic int model_lane(int lane, int bw);
      int s = 0;
      logic signed [BW_W-1:0] w;
      foreach (pass_addrs[k]) begin
         w = twm[pass_addrs[k]][lane*BW_W +: BW_W];
         s = s + int'(w);
         if (s > (1 << (bw-1)) - 1) s = (1 << (bw-1)) - 1;
         else if (s < -(1 << (bw-1))) s = -(1 << (bw-1));
      end
      return s;
   endfunction

   function automatic logic [NUM_OUT*ACC_A-1:0] exp_a();
      logic [NUM_OUT*ACC_A-1:0] r;
      int s;
      r = '0;
      for (int l = 0; l < NUM_OUT; l++) begin
         s = model_lane(l, ACC_A);
         r[l*ACC_A +: ACC_A] = s[ACC_A-1:0];
      end
      return r;
   endfunction

   function automatic logic [NUM_OUT*ACC_B-1:0] exp_b();
      logic [NUM_OUT*ACC_B-1:0] r;
      int s;
      r = '0;
      for (int l = 0; l < NUM_OUT; l++) begin
         s = model_lane(l, ACC_B);
         r[l*ACC_B +: ACC_B] = s[ACC_B-1:0];
      end
      return r;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   int r_pops, r_first_pop, r_last_pop, r_reads, r_bad_pop;
   int r_valid_cyc_a, r_pulses_a, r_pulses_b;
   logic r_busy_after;
   logic [NUM_OUT*ACC_A-1:0] r_acc_a, r_acc_after;
   logic [NUM_OUT*ACC_B-1:0] r_acc_b;

   task automatic start_pass();
      @(negedge clk_f); start = 1'b1;
      @(negedge clk_f); start = 1'b0;
   endtask

   // Pushes pass_addrs with random gaps and records what the DUT did.
   // gf_early: gen_finished is a single pulse one cycle before the final push;
   // the last pushes are then back-to-back so the FIFO is never empty while
   // the generator is still going to push.
   task automatic drive_pass(input int gap_max, input bit gf_early, input bit poke_start);
      int push_cyc[$];
      int c = 0;
      int last_push;
      int pidx = 0;
      int post = -1;
      foreach (pass_addrs[k]) begin
         int g;
         g = (gap_max == 0) ? 0 : int'($urandom_range(gap_max));
         if (gf_early && k >= pass_addrs.size() - 2) g = 0;
         c += g;
         push_cyc.push_back(c);
         c++;
      end
      last_push = (push_cyc.size() > 0) ? push_cyc[push_cyc.size()-1] : -1;
      r_pops = 0; r_first_pop = -1; r_last_pop = -1; r_reads = 0; r_bad_pop = 0;
      r_valid_cyc_a = -1; r_pulses_a = 0; r_pulses_b = 0; r_busy_after = 1'b1;
      r_acc_a = '0; r_acc_b = '0; r_acc_after = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk_f);
         if (en_fetch_a) begin
            if (r_pops == 0) r_first_pop = cyc;
            r_pops++;
            r_last_pop = cyc;
            if (empty_fifo) r_bad_pop++;
         end
         if (mem_rd_en_a) r_reads++;
         if (acc_valid_a) begin
            if (r_pulses_a == 0) begin
               r_valid_cyc_a = cyc;
               r_acc_a = acc_out_a;
            end
            r_pulses_a++;
         end
         if (acc_valid_b) begin
            if (r_pulses_b == 0) r_acc_b = acc_out_b;
            r_pulses_b++;
         end
         if (post >= 0 && cyc == post + 1) begin
            r_busy_after = busy_a | busy_b;
            r_acc_after  = acc_out_a;
         end
         if (post >= 0 && cyc >= post + 3) break;
         start    = 1'b0;
         push_req = 1'b0;
         if (pidx < push_cyc.size() && cyc == push_cyc[pidx]) begin
            push_req  = 1'b1;
            push_addr = pass_addrs[pidx];
            pidx++;
         end
         if (gf_early) gen_finished = (cyc == last_push - 1);
         else          gen_finished = (cyc > last_push);
         if (poke_start && cyc == 2) start = 1'b1;
         if (acc_valid_a && post < 0) begin
            post = cyc;
            if (poke_start) start = 1'b1;   // start on the acc_valid cycle
         end
      end
      push_req = 1'b0; gen_finished = 1'b0; start = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int cnt_v;
      int cnt_f;
      rst = 1'b1;
      repeat (2) @(negedge clk_f);
      rst = 1'b0;
      @(negedge clk_f);
      checks++; if ({en_fetch_a, mem_rd_en_a, acc_valid_a, busy_a} !== 4'b0) begin failures++; $display("FAIL reset_ctrl_a: got %b want 0000", {en_fetch_a, mem_rd_en_a, acc_valid_a, busy_a}); end
      checks++; if ({en_fetch_b, mem_rd_en_b, acc_valid_b, busy_b} !== 4'b0) begin failures++; $display("FAIL reset_ctrl_b: got %b want 0000", {en_fetch_b, mem_rd_en_b, acc_valid_b, busy_b}); end
      checks++; if (acc_out_a !== '0) begin failures++; $display("FAIL reset_acc_a: got %h want 0", acc_out_a); end
      checks++; if (acc_out_b !== '0) begin failures++; $display("FAIL reset_acc_b: got %h want 0", acc_out_b); end

      // Mid-pass reset with rows in flight.
      for (int r = 0; r < 32; r++) twm[r] = {$urandom, $urandom, $urandom, $urandom};
      start_pass();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_f); push_req = 1'b1; push_addr = BW_ADDR'(k);
      end
      @(negedge clk_f); push_req = 1'b0;
      @(negedge clk_f);
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_midpass_busy: got %b want 1", busy_a); end
      rst = 1'b1;
      repeat (2) @(negedge clk_f);
      rst = 1'b0;
      checks++; if ({en_fetch_a, mem_rd_en_a, acc_valid_a, busy_a} !== 4'b0) begin failures++; $display("FAIL reset_midpass_ctrl: got %b want 0000", {en_fetch_a, mem_rd_en_a, acc_valid_a, busy_a}); end
      checks++; if (acc_out_a !== '0) begin failures++; $display("FAIL reset_midpass_acc_a: got %h want 0", acc_out_a); end
      checks++; if (acc_out_b !== '0) begin failures++; $display("FAIL reset_midpass_acc_b: got %h want 0", acc_out_b); end
      cnt_v = 0; cnt_f = 0;
      repeat (8) begin
         @(negedge clk_f);
         if (acc_valid_a || acc_valid_b) cnt_v++;
         if (en_fetch_a || mem_rd_en_a || busy_a) cnt_f++;
      end
      checks++; if (cnt_v !== 0) begin failures++; $display("FAIL reset_no_valid: got %0d pulses want 0", cnt_v); end
      checks++; if (cnt_f !== 0) begin failures++; $display("FAIL reset_stays_idle: got %0d active cycles want 0", cnt_f); end
      $display("test_reset done checks=%0d", checks);
   endtask

   task automatic test_single();
      int n;
      for (int l = 0; l < NUM_OUT; l++) twm[4][l*BW_W +: BW_W] = BW_W'(l + 1);
      pass_addrs = {5'd4};
      start_pass();
      @(negedge clk_f); push_req = 1'b1; push_addr = 5'd4;
      @(negedge clk_f); push_req = 1'b0;
      checks++; if ({en_fetch_a, mem_rd_en_a} !== 2'b10) begin failures++; $display("FAIL single_pop: got en_fetch,mem_rd_en=%b want 10", {en_fetch_a, mem_rd_en_a}); end
      @(negedge clk_f);
      checks++; if ({en_fetch_a, mem_rd_en_a} !== 2'b01) begin failures++; $display("FAIL single_read: got en_fetch,mem_rd_en=%b want 01", {en_fetch_a, mem_rd_en_a}); end
      checks++; if (mem_rd_addr_a !== 5'd4) begin failures++; $display("FAIL single_rd_addr: got %0d want 4", mem_rd_addr_a); end
      gen_finished = 1'b1;
      @(negedge clk_f);
      checks++; if ({mem_rd_en_a, mem_rd_addr_a} !== {1'b0, 5'd4}) begin failures++; $display("FAIL single_addr_hold: got en=%b addr=%0d want en=0 addr=4", mem_rd_en_a, mem_rd_addr_a); end
      n = 0;
      while (!acc_valid_a && n < 10) begin @(negedge clk_f); n++; end
      checks++; if (n !== 1) begin failures++; $display("FAIL single_valid_latency: got %0d want 1", n); end
      checks++; if (acc_out_a !== exp_a()) begin failures++; $display("FAIL single_acc_a: got %h want %h", acc_out_a, exp_a()); end
      checks++; if (acc_out_b !== exp_b()) begin failures++; $display("FAIL single_acc_b: got %h want %h", acc_out_b, exp_b()); end
      gen_finished = 1'b0;
      @(negedge clk_f);
      checks++; if ({acc_valid_a, busy_a} !== 2'b00) begin failures++; $display("FAIL single_after: got valid,busy=%b want 00", {acc_valid_a, busy_a}); end
      checks++; if (acc_out_a !== exp_a()) begin failures++; $display("FAIL single_acc_held: got %h want %h", acc_out_a, exp_a()); end
      $display("test_single done checks=%0d", checks);
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 4; r++) twm[r] = {NUM_OUT{8'h01}};
      pass_addrs = {5'd0, 5'd1, 5'd2, 5'd3};
      start_pass();
      drive_pass(0, 1'b0, 1'b0);
      checks++; if (r_pops !== 4) begin failures++; $display("FAIL b2b_pops: got %0d want 4", r_pops); end
      checks++; if (r_last_pop - r_first_pop !== 3) begin failures++; $display("FAIL b2b_consecutive: got span %0d want 3", r_last_pop - r_first_pop); end
      checks++; if (r_valid_cyc_a - r_last_pop !== 3) begin failures++; $display("FAIL b2b_latency: got %0d want 3", r_valid_cyc_a - r_last_pop); end
      checks++; if (r_pulses_a !== 1 || r_pulses_b !== 1) begin failures++; $display("FAIL b2b_pulses: got %0d/%0d want 1/1", r_pulses_a, r_pulses_b); end
      checks++; if (r_acc_a !== exp_a()) begin failures++; $display("FAIL b2b_acc_a: got %h want %h", r_acc_a, exp_a()); end
      checks++; if (r_acc_b !== exp_b()) begin failures++; $display("FAIL b2b_acc_b: got %h want %h", r_acc_b, exp_b()); end
      checks++; if (r_bad_pop !== 0) begin failures++; $display("FAIL b2b_pop_when_empty: got %0d want 0", r_bad_pop); end
      $display("test_back_to_back done checks=%0d", checks);
   endtask

   task automatic test_empty();
      pass_addrs.delete();
      start_pass();
      drive_pass(0, 1'b0, 1'b0);
      checks++; if (r_pops !== 0 || r_reads !== 0) begin failures++; $display("FAIL empty_no_activity: got pops=%0d reads=%0d want 0/0", r_pops, r_reads); end
      checks++; if (r_pulses_a !== 1 || r_valid_cyc_a < 0 || r_valid_cyc_a > 2) begin failures++; $display("FAIL empty_valid: got pulses=%0d cyc=%0d want 1 pulse by cyc 2", r_pulses_a, r_valid_cyc_a); end
      checks++; if (r_acc_a !== '0 || r_acc_b !== '0) begin failures++; $display("FAIL empty_acc: got %h / %h want 0", r_acc_a, r_acc_b); end
      $display("test_empty done checks=%0d", checks);
   endtask

   task automatic test_saturation();
      int want_b[3] = '{127, -128, 0};
      int want_a[3] = '{200, -300, 0};
      logic signed [ACC_B-1:0] lane_b;
      logic signed [ACC_A-1:0] lane_a;
      twm[10] = {NUM_OUT{8'd100}};
      twm[11] = {NUM_OUT{8'h9C}};   // -100
      for (int p = 0; p < 3; p++) begin
         case (p)
            0: pass_addrs = {5'd10, 5'd10};
            1: pass_addrs = {5'd11, 5'd11, 5'd11};
            default: pass_addrs = {5'd10, 5'd11};
         endcase
         start_pass();
         drive_pass(1, 1'b0, 1'b0);
         lane_b = r_acc_b[(p*5 % NUM_OUT)*ACC_B +: ACC_B];
         lane_a = r_acc_a[(p*5 % NUM_OUT)*ACC_A +: ACC_A];
         checks++; if (int'(lane_b) !== want_b[p]) begin failures++; $display("FAIL sat_lane_b pass %0d: got %0d want %0d", p, lane_b, want_b[p]); end
         checks++; if (int'(lane_a) !== want_a[p]) begin failures++; $display("FAIL sat_lane_a pass %0d: got %0d want %0d", p, lane_a, want_a[p]); end
         checks++; if (r_acc_b !== exp_b()) begin failures++; $display("FAIL sat_acc_b pass %0d: got %h want %h", p, r_acc_b, exp_b()); end
         checks++; if (r_acc_a !== exp_a()) begin failures++; $display("FAIL sat_acc_a pass %0d: got %h want %h", p, r_acc_a, exp_a()); end
      end
      $display("test_saturation done checks=%0d", checks);
   endtask

   task automatic test_gaps();
      int n;
      for (int it = 0; it < 3; it++) begin
         for (int r = 0; r < 32; r++) twm[r] = {$urandom, $urandom, $urandom, $urandom};
         pass_addrs.delete();
         n = 8 + int'($urandom_range(4));
         for (int k = 0; k < n; k++) pass_addrs.push_back(BW_ADDR'($urandom_range(31)));
         start_pass();
         drive_pass(3, 1'b1, 1'b1);
         checks++; if (r_pops !== n || r_reads !== n) begin failures++; $display("FAIL gaps_rows it %0d: got pops=%0d reads=%0d want %0d", it, r_pops, r_reads, n); end
         checks++; if (r_pulses_a !== 1 || r_pulses_b !== 1) begin failures++; $display("FAIL gaps_pulses it %0d: got %0d/%0d want 1/1", it, r_pulses_a, r_pulses_b); end
         checks++; if (r_acc_a !== exp_a()) begin failures++; $display("FAIL gaps_acc_a it %0d: got %h want %h", it, r_acc_a, exp_a()); end
         checks++; if (r_acc_b !== exp_b()) begin failures++; $display("FAIL gaps_acc_b it %0d: got %h want %h", it, r_acc_b, exp_b()); end
         checks++; if (r_bad_pop !== 0) begin failures++; $display("FAIL gaps_pop_when_empty it %0d: got %0d want 0", it, r_bad_pop); end
         checks++; if (r_busy_after !== 1'b0) begin failures++; $display("FAIL gaps_start_on_valid it %0d: got busy=%b want 0", it, r_busy_after); end
         checks++; if (r_acc_after !== exp_a()) begin failures++; $display("FAIL gaps_acc_held it %0d: got %h want %h", it, r_acc_after, exp_a()); end
      end
      $display("test_gaps done checks=%0d", checks);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; gen_finished = 1'b0;
      push_req = 1'b0; push_addr = '0;
      for (int r = 0; r < 32; r++) twm[r] = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_empty();
      test_saturation();
      test_gaps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
